// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases per-domain resets and clock enables one domain at a
// time in index order. Each domain must report ready before the next one is
// released. Also handles a 4-phase soft-reset handshake and a sticky
// ready-timeout error that can be cleared by ERR_CLR.
module rst_seq_ctrl #(
   parameter int NUM_DOMAINS   = 4,
   parameter int INIT_DELAY    = 4,
   parameter int STAGE_DELAY   = 8,
   parameter int HOLD_CYCLES   = 16,
   parameter int READY_TIMEOUT = 1024,
   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
   input  logic                   USER_CLK,
   input  logic                   USER_RST,
   output logic [NUM_DOMAINS-1:0] DOM_RST,
   output logic [NUM_DOMAINS-1:0] DOM_CE,
   input  logic [NUM_DOMAINS-1:0] DOM_READY,
   input  logic                   SW_RST_REQ,
   output logic                   SW_RST_ACK,
   output logic                   SEQ_DONE,
   output logic                   SEQ_ERROR,
   output logic [IDX_W-1:0]       ERR_DOMAIN,
   input  logic                   ERR_CLR
);

   // One shared down-counter, sized for the largest delay it ever loads.
   localparam int MAX_A   = (INIT_DELAY > STAGE_DELAY) ? INIT_DELAY : STAGE_DELAY;
   localparam int MAX_B   = (HOLD_CYCLES > READY_TIMEOUT) ? HOLD_CYCLES : READY_TIMEOUT;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_INIT_WAIT,
      S_WAIT_READY,
      S_GAP,
      S_RUNNING,
      S_HOLD,
      S_ERROR
   } state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt;
   logic [CW-1:0]          count, count_nxt;
   logic [NUM_DOMAINS-1:0] rst_q, rst_nxt;
   logic [NUM_DOMAINS-1:0] ce_q, ce_nxt;
   logic                   ack_q, ack_nxt;
   logic                   done_q, done_nxt;
   logic                   err_q, err_nxt;
   logic [IDX_W-1:0]       err_dom_q, err_dom_nxt;
   logic                   pending, pending_nxt;

   // Next-state and next-output logic for the sequencer FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_nxt   = state;
      idx_nxt     = idx;
      count_nxt   = count;
      rst_nxt     = rst_q;
      ce_nxt      = ce_q;
      ack_nxt     = ack_q;
      done_nxt    = done_q;
      err_nxt     = err_q;
      err_dom_nxt = err_dom_q;
      pending_nxt = pending;

      // ACK completes the handshake once the requester lets go.
      if (ack_q && !SW_RST_REQ) ack_nxt = 1'b0;

      case (state)
         S_INIT_WAIT: begin
            if (count == CNT_ONE) begin
               idx_nxt    = '0;
               rst_nxt[0] = 1'b0;
               ce_nxt[0]  = 1'b1;
               count_nxt  = CW'(READY_TIMEOUT);
               state_nxt  = S_WAIT_READY;
            end else begin
               count_nxt = count - CNT_ONE;
            end
         end

         S_WAIT_READY: begin
            if (DOM_READY[idx]) begin
               if (idx == LAST_IDX) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_RUNNING;
                  if (pending) begin
                     ack_nxt     = 1'b1;
                     pending_nxt = 1'b0;
                  end
               end else if (STAGE_DELAY == 0) begin
                  // Zero gap: the next domain is released on the same edge that sees ready.
                  idx_nxt                  = idx + IDX_W'(1);
                  rst_nxt[idx + IDX_W'(1)] = 1'b0;
                  ce_nxt[idx + IDX_W'(1)]  = 1'b1;
                  count_nxt                = CW'(READY_TIMEOUT);
               end else begin
                  count_nxt = CW'(STAGE_DELAY);
                  state_nxt = S_GAP;
               end
            end else if (count == CNT_ONE) begin
               err_nxt     = 1'b1;
               err_dom_nxt = idx;
               rst_nxt     = '1;
               ce_nxt      = '0;
               state_nxt   = S_ERROR;
            end else begin
               count_nxt = count - CNT_ONE;
            end
         end

         S_GAP: begin
            if (count == CNT_ONE) begin
               idx_nxt                  = idx + IDX_W'(1);
               rst_nxt[idx + IDX_W'(1)] = 1'b0;
               ce_nxt[idx + IDX_W'(1)]  = 1'b1;
               count_nxt                = CW'(READY_TIMEOUT);
               state_nxt                = S_WAIT_READY;
            end else begin
               count_nxt = count - CNT_ONE;
            end
         end

         S_RUNNING: begin
            // A request still being acknowledged must not retrigger.
            if (SW_RST_REQ && !ack_q) begin
               pending_nxt = 1'b1;
               done_nxt    = 1'b0;
               rst_nxt     = '1;
               ce_nxt      = '0;
               count_nxt   = CW'(HOLD_CYCLES);
               state_nxt   = S_HOLD;
            end
         end

         S_HOLD: begin
            if (count == CNT_ONE) begin
               count_nxt = CW'(INIT_DELAY);
               state_nxt = S_INIT_WAIT;
            end else begin
               count_nxt = count - CNT_ONE;
            end
         end

         S_ERROR: begin
            if (ERR_CLR) begin
               err_nxt   = 1'b0;
               count_nxt = CW'(HOLD_CYCLES);
               state_nxt = S_HOLD;
            end
         end

         default: begin
            rst_nxt   = '1;
            ce_nxt    = '0;
            done_nxt  = 1'b0;
            count_nxt = CW'(INIT_DELAY);
            state_nxt = S_INIT_WAIT;
         end
      endcase
   end

   // State and registered outputs; USER_RST overrides everything at the edge it is sampled.
   always_ff @(posedge USER_CLK) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (USER_RST) begin
         state     <= S_INIT_WAIT;
         idx       <= '0;
         count     <= CW'(INIT_DELAY);
         rst_q     <= '1;
         ce_q      <= '0;
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_dom_q <= '0;
         pending   <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         count     <= count_nxt;
         rst_q     <= rst_nxt;
         ce_q      <= ce_nxt;
         ack_q     <= ack_nxt;
         done_q    <= done_nxt;
         err_q     <= err_nxt;
         err_dom_q <= err_dom_nxt;
         pending   <= pending_nxt;
      end
   end

   assign DOM_RST    = rst_q;
   assign DOM_CE     = ce_q;
   assign SW_RST_ACK = ack_q;
   assign SEQ_DONE   = done_q;
   assign SEQ_ERROR  = err_q;
   assign ERR_DOMAIN = err_dom_q;

endmodule
